reaction_controller: RTL and testbench

REACTION_CONTROLLER -- requirements
Module: reaction_controller

---
 rtl/reaction_controller.sv | 106 ++++++++++
 tb/tb_reaction_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reaction_controller.sv
// reaction_controller: reaction-time game FSM with GO window, false-start/timeout flags and best/round statistics
module reaction_controller #(
    parameter int TIMEOUT_MS = 2000,
    parameter int CNT_W      = 14
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_btn,
    input  logic             react_btn,
    input  logic             clear_btn,
    input  logic             random_finish,
    output logic             random_start,
    output logic             led_go,
    output logic [CNT_W-1:0] reaction_ms,
    output logic             result_valid,
    output logic [CNT_W-1:0] best_ms,
    output logic [7:0]       round_cnt,
    output logic             false_start,
    output logic             timeout
);
    typedef enum logic [2:0] {IDLE, ARM, GO, RESULT, FAULT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_MS - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] elapsed;
    logic             done;
    logic             go_hit;
    logic             go_expire;
    logic             restart;
    logic             do_clear;

    assign done      = state == RESULT || state == FAULT;
    assign elapsed   = counter + 1'b1;
    assign go_hit    = state == GO && react_btn;
    assign go_expire = state == GO && !react_btn && counter == LAST;
    assign restart   = done && start_btn;
    assign do_clear  = clear_btn && (state == IDLE || (done && !start_btn));

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // next-state logic; false start beats random_finish, start beats clear
    always_comb begin
        next_state = state;
        case (state)
            IDLE:          next_state = start_btn ? ARM : IDLE;
            ARM:           next_state = react_btn ? FAULT : random_finish ? GO : ARM;
            GO:            next_state = react_btn ? RESULT : counter == LAST ? FAULT : GO;
            RESULT, FAULT: next_state = start_btn ? ARM : clear_btn ? IDLE : state;
            default:       next_state = IDLE;
        endcase
    end

    // state-decoded outputs; the delay generator reloads whenever we are outside ARM/GO
    always_comb begin
        random_start = state == ARM || state == GO;
        led_go       = state == GO;
    end

    // GO-window counter, zero on every GO entry and bounded by the timeout
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                              counter <= '0;
        else if (state == GO && next_state == GO)  counter <= elapsed;
        else                                       counter <= '0;
    end

    // sticky fault flags, cleared when a new round starts or on clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            false_start <= 1'b0;
            timeout     <= 1'b0;
        end else if (restart || do_clear) begin
            false_start <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            false_start <= false_start | (state == ARM && react_btn);
            timeout     <= timeout | go_expire;
        end
    end

    // result pulse and statistics, all updated on RESULT entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_valid <= 1'b0;
            reaction_ms  <= '0;
            best_ms      <= '1;
            round_cnt    <= '0;
        end else begin
            result_valid <= go_hit;
            if (go_hit) begin
                reaction_ms <= elapsed;
                best_ms     <= elapsed < best_ms ? elapsed : best_ms;
                round_cnt   <= round_cnt == 8'hff ? round_cnt : round_cnt + 8'd1;
            end else if (do_clear) begin
                reaction_ms <= '0;
                best_ms     <= '1;
                round_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_reaction_controller.sv
// tb_reaction_controller: randomized scenario bench against a round-level reference model
module tb_reaction_controller;
    localparam int TMO  = 2000;
    localparam int CW   = 14;
    localparam int NONE = (1 << CW) - 1;

    logic          clock = 0, reset_n = 0;
    logic          start_btn = 0, react_btn = 0, clear_btn = 0, random_finish = 0;
    logic          random_start, led_go, result_valid, false_start, timeout;
    logic [CW-1:0] reaction_ms, best_ms;
    logic [7:0]    round_cnt;

    reaction_controller #(.TIMEOUT_MS(TMO), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .start_btn(start_btn), .react_btn(react_btn),
        .clear_btn(clear_btn), .random_finish(random_finish), .random_start(random_start),
        .led_go(led_go), .reaction_ms(reaction_ms), .result_valid(result_valid),
        .best_ms(best_ms), .round_cnt(round_cnt), .false_start(false_start), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int   n_vec = 0, n_bad = 0;
    int   exp_react = 0, exp_best = NONE, exp_rounds = 0;
    logic exp_fs = 0, exp_to = 0;
    logic in_idle = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_react"}, reaction_ms, exp_react);
        check({tag, "_best"},  best_ms, exp_best);
        check({tag, "_rounds"}, round_cnt, exp_rounds);
        check({tag, "_fs"},    false_start, exp_fs);
        check({tag, "_to"},    timeout, exp_to);
    endtask

    task automatic model_clear;
        exp_react = 0; exp_best = NONE; exp_rounds = 0; exp_fs = 0; exp_to = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rs"}, random_start, 0);
        check({tag, "_go"}, led_go, 0);
        check({tag, "_rv"}, result_valid, 0);
        check_stats(tag);
    endtask

    task automatic do_clear;
        clear_btn = 1;
        step;
        clear_btn = 0;
        model_clear();
        in_idle = 1;
        check_idle_outputs("clear");
    endtask

    task automatic start_round(input bit with_clear);
        start_btn = 1;
        clear_btn = with_clear && !in_idle;
        step;
        start_btn = 0;
        clear_btn = 0;
        exp_fs = 0; exp_to = 0; in_idle = 0;
        check("arm_rs", random_start, 1);
        check("arm_go", led_go, 0);
        check_stats("arm");
    endtask

    task automatic arm_wait(input int d);
        for (int i = 0; i < d; i++) begin
            start_btn = ($urandom % 4) == 0;
            clear_btn = ($urandom % 4) == 0;
            step;
            check("armw_go", led_go, 0);
            check("armw_rs", random_start, 1);
        end
        start_btn = 0; clear_btn = 0;
    endtask

    task automatic false_start_round;
        react_btn = 1;
        random_finish = $urandom_range(0, 1);
        step;
        react_btn = 0; random_finish = 0;
        exp_fs = 1;
        check("fs_go", led_go, 0);
        check("fs_rs", random_start, 0);
        check("fs_rv", result_valid, 0);
        check_stats("fs");
    endtask

    task automatic enter_go;
        random_finish = 1;
        step;
        random_finish = $urandom_range(0, 1);
        check("go_led", led_go, 1);
        check("go_rs", random_start, 1);
    endtask

    // k = reaction cycle (1..TMO), 0 = no press
    task automatic go_phase(input int k);
        int lim = k == 0 ? TMO : k;
        enter_go();
        for (int j = 1; j < lim; j++) begin
            start_btn = ($urandom % 8) == 0;
            clear_btn = ($urandom % 8) == 0;
            step;
            check("gow_led", led_go, 1);
        end
        start_btn = 0; clear_btn = 0;
        react_btn = k != 0;
        step;
        react_btn = 0; random_finish = 0;
        check("end_led", led_go, 0);
        check("end_rs", random_start, 0);
        if (k != 0) begin
            exp_react = k;
            if (k < exp_best) exp_best = k;
            if (exp_rounds < 255) exp_rounds++;
            check("res_rv", result_valid, 1);
            check_stats("res");
            react_btn = 1;
            step;
            react_btn = 0;
            check("res_rv_drop", result_valid, 0);
            check_stats("res_hold");
        end else begin
            exp_to = 1;
            check("to_rv", result_valid, 0);
            check_stats("to");
        end
    endtask

    task automatic full_round(input int d, input int k);
        start_round(0);
        arm_wait(d);
        go_phase(k);
    endtask

    initial begin
        repeat (3) step;
        check_idle_outputs("reset");
        reset_n = 1;
        step;
        check_idle_outputs("post_reset");
        react_btn = 1;
        step;
        react_btn = 0;
        check_idle_outputs("idle_react");

        full_round(800, 250);
        start_round(0);
        arm_wait(10);
        false_start_round();
        full_round(5, 0);
        full_round(5, TMO);

        do_clear();
        full_round(3, 300);
        full_round(3, 200);
        full_round(3, 400);
        check("best3", best_ms, 200);
        check("rounds3", round_cnt, 3);
        do_clear();
        check("cleared_best", best_ms, NONE);

        full_round(2, 77);
        start_round(1);
        check("start_wins_rounds", round_cnt, 1);
        arm_wait(5);
        enter_go();
        repeat (99) step;
        #2 reset_n = 0;
        #1;
        model_clear();
        in_idle = 1;
        check_idle_outputs("async_rst");
        step;
        check("rst_hold_rv", result_valid, 0);
        reset_n = 1;
        full_round(20, 123);

        for (int r = 0; r < 40; r++) begin
            int kind = $urandom_range(0, 19);
            if (!in_idle && ($urandom % 6) == 0) do_clear();
            start_round($urandom % 3 == 0);
            arm_wait($urandom_range(0, 40));
            if (kind < 2)       false_start_round();
            else if (kind == 2) go_phase(0);
            else                go_phase($urandom_range(1, 400));
        end

        do_clear();
        for (int r = 0; r < 260; r++) begin
            start_round(0);
            arm_wait($urandom_range(0, 1));
            go_phase($urandom_range(1, 3));
        end
        check("sat_rounds", round_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
